// File: rtl/cam_cfg_pkg.sv
// rtl/cam_cfg_pkg.sv - shared types and constants for the camera config sequencer
package cam_cfg_pkg;

  localparam int DELAY_UNIT_DEF = 100000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_RESP,
    S_WAIT,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_e;

  typedef enum logic [1:0] {
    E_WRITE,
    E_DELAY,
    E_END
  } entry_e;

  // A marker reg field selects delay or end; an all-ones value under the marker means end.
  function automatic entry_e classify(input logic reg_is_mark, input logic val_is_end);
    if (reg_is_mark && val_is_end) return E_END;
    if (reg_is_mark) return E_DELAY;
    return E_WRITE;
  endfunction

endpackage

// File: rtl/cam_cfg_delay_timer.sv
// rtl/cam_cfg_delay_timer.sv - loads value*unit and counts down; expired on the last tick
module cam_cfg_delay_timer #(
  parameter int VAL_W      = 8,
  parameter int DELAY_UNIT = 100000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [VAL_W-1:0] value_i,
  output logic             expired_o
);

  localparam longint unsigned MAX_TICKS =
    64'(DELAY_UNIT) * ((64'd1 << VAL_W) - 64'd1);
  localparam int CNT_W = $clog2(MAX_TICKS + 64'd1);
  localparam logic [CNT_W-1:0] UNIT_C = CNT_W'(DELAY_UNIT);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(value_i) * UNIT_C;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE_C;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags the final cycle so a wait of N lasts exactly N cycles.
  assign expired_o = (cnt_q <= ONE_C);

endmodule

// File: rtl/cam_cfg_sequencer.sv
// rtl/cam_cfg_sequencer.sv - walks a {reg,val} config ROM and issues SCCB register writes
module cam_cfg_sequencer
  import cam_cfg_pkg::*;
#(
  parameter int                IDX_W      = 8,
  parameter int                REG_W      = 8,
  parameter int                VAL_W      = 8,
  parameter int                DELAY_UNIT = DELAY_UNIT_DEF,
  parameter int                MAX_RETRY  = 3,
  parameter logic [REG_W-1:0]  MARK_REG   = '1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  output logic [IDX_W-1:0]       rom_addr_o,
  input  logic [REG_W+VAL_W-1:0] rom_data_i,
  output logic                   cmd_valid_o,
  input  logic                   cmd_ready_i,
  output logic [REG_W-1:0]       cmd_reg_o,
  output logic [VAL_W-1:0]       cmd_val_o,
  input  logic                   resp_valid_i,
  input  logic                   resp_nack_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [IDX_W-1:0]       err_index_o,
  output logic [IDX_W:0]         write_count_o
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);
  localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W:0]     WC_ONE    = (IDX_W + 1)'(1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [REG_W-1:0]   cmd_reg_q, cmd_reg_d;
  logic [VAL_W-1:0]   cmd_val_q, cmd_val_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [IDX_W-1:0]   err_index_q, err_index_d;
  logic [IDX_W:0]     wc_q, wc_d;

  logic [REG_W-1:0] rom_reg;
  logic [VAL_W-1:0] rom_val;
  logic             timer_load;
  logic             timer_expired;

  assign rom_reg = rom_data_i[REG_W+VAL_W-1 -: REG_W];
  assign rom_val = rom_data_i[VAL_W-1:0];

  cam_cfg_delay_timer #(
    .VAL_W      (VAL_W),
    .DELAY_UNIT (DELAY_UNIT)
  ) u_delay_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (timer_load),
    .value_i   (rom_val),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    cmd_reg_d   = cmd_reg_q;
    cmd_val_d   = cmd_val_q;
    done_d      = done_q;
    error_d     = error_q;
    err_index_d = err_index_q;
    wc_d        = wc_q;
    timer_load  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d   = '0;
          wc_d    = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        unique case (classify(rom_reg == MARK_REG, rom_val == '1))
          E_END: begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
          E_DELAY: begin
            if (rom_val == '0) begin
              state_d = S_NEXT;
            end else begin
              timer_load = 1'b1;
              state_d    = S_WAIT;
            end
          end
          default: begin
            cmd_reg_d = rom_reg;
            cmd_val_d = rom_val;
            retry_d   = '0;
            state_d   = S_SEND;
          end
        endcase
      end
      S_SEND: begin
        if (cmd_ready_i) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_valid_i) begin
          if (!resp_nack_i) begin
            wc_d    = wc_q + WC_ONE;
            state_d = S_NEXT;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RETRY_ONE;
            state_d = S_SEND;
          end else begin
            error_d     = 1'b1;
            err_index_d = idx_q;
            state_d     = S_ERROR;
          end
        end
      end
      S_WAIT: begin
        if (timer_expired) state_d = S_NEXT;
      end
      // The last ROM slot ends the run rather than wrapping back to entry 0.
      S_NEXT: begin
        if (idx_q == '1) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      cmd_reg_q   <= '0;
      cmd_val_q   <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
      wc_q        <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      cmd_reg_q   <= cmd_reg_d;
      cmd_val_q   <= cmd_val_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
      wc_q        <= wc_d;
    end
  end

  assign rom_addr_o    = idx_q;
  assign cmd_valid_o   = (state_q == S_SEND);
  assign cmd_reg_o     = cmd_reg_q;
  assign cmd_val_o     = cmd_val_q;
  assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign err_index_o   = err_index_q;
  assign write_count_o = wc_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// tb/tb_cam_cfg_sequencer.sv - randomized and directed bench with a ROM-walk reference model
module tb_cam_cfg_sequencer;

  localparam int DU = 10;
  localparam int MR = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [7:0]  rom_addr_o;
  logic [15:0] rom_data_i;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [7:0]  cmd_reg_o;
  logic [7:0]  cmd_val_o;
  logic        resp_valid_i;
  logic        resp_nack_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [7:0]  err_index_o;
  logic [8:0]  write_count_o;

  cam_cfg_sequencer #(
    .IDX_W(8), .REG_W(8), .VAL_W(8), .DELAY_UNIT(DU), .MAX_RETRY(MR)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_reg_o(cmd_reg_o), .cmd_val_o(cmd_val_o),
    .resp_valid_i(resp_valid_i), .resp_nack_i(resp_nack_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .err_index_o(err_index_o), .write_count_o(write_count_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [15:0] rom [256];
  always @(posedge clk_i) rom_data_i <= rom[rom_addr_o];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Responder state shared with the main sequence.
  int          stall_req = 0;
  int          ack_lat   = 2;
  bit          nack_q[$];
  logic [15:0] hs_log[$];
  int          resp_cyc[$];
  int          rise_cyc[$];

  // Reference model results.
  int          plan[$];
  logic [15:0] exp_log[$];
  int          exp_gap[$];
  int          exp_first;
  int          exp_wc;
  bit          exp_err;
  int          exp_err_idx;

  // Cycle costs: each delay entry adds fetch+decode+next plus val*DU;
  // a write follows its predecessor's response after 4 cycles; a retry after 1.
  task automatic build_model();
    int extra;
    int pi;
    int n;
    int tries;
    exp_log.delete(); exp_gap.delete(); nack_q.delete();
    exp_wc = 0; exp_err = 0; exp_err_idx = 0; exp_first = 0;
    extra = 0; pi = 0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] r;
      logic [7:0] v;
      r = rom[i][15:8];
      v = rom[i][7:0];
      if (r == 8'hFF) begin
        if (v == 8'hFF) break;
        extra += 3 + int'(v) * DU;
        continue;
      end
      n = (pi < plan.size()) ? plan[pi] : 0;
      pi++;
      tries = (n > MR) ? MR + 1 : n + 1;
      for (int t = 0; t < tries; t++) begin
        if (exp_log.size() == 0) exp_first = 3 + extra;
        else exp_gap.push_back((t == 0) ? 4 + extra : 1);
        exp_log.push_back(rom[i]);
        nack_q.push_back(t < n);
      end
      extra = 0;
      if (n > MR) begin
        exp_err = 1;
        exp_err_idx = i;
        break;
      end
      exp_wc++;
    end
  endtask

  initial begin : responder
    logic [7:0] h_reg;
    logic [7:0] h_val;
    int n;
    bit nk;
    cmd_ready_i = 1'b1; resp_valid_i = 1'b0; resp_nack_i = 1'b0;
    forever begin
      @(negedge clk_i);
      while (!rst_i && cmd_valid_o) begin
        if (stall_req > 0) begin
          n = stall_req; stall_req = 0;
          h_reg = cmd_reg_o; h_val = cmd_val_o;
          cmd_ready_i = 1'b0;
          for (int k = 0; k < n; k++) begin
            @(negedge clk_i);
            if (rst_i) break;
            chk("stall_hold", {15'd0, cmd_valid_o, cmd_reg_o, cmd_val_o}, {15'd0, 1'b1, h_reg, h_val});
          end
          cmd_ready_i = 1'b1;
          if (rst_i || !cmd_valid_o) break;
        end
        hs_log.push_back({cmd_reg_o, cmd_val_o});
        nk = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        repeat (ack_lat) @(negedge clk_i);
        resp_valid_i = 1'b1; resp_nack_i = nk; resp_cyc.push_back(cyc);
        @(negedge clk_i);
        resp_valid_i = 1'b0; resp_nack_i = 1'b0;
      end
    end
  end

  initial begin : rise_monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (cmd_valid_o === 1'b1 && !prev) rise_cyc.push_back(cyc);
      prev = (cmd_valid_o === 1'b1);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rom_addr"}, 32'(rom_addr_o), 0);
    chk({tag, "_cmd"}, {15'd0, cmd_valid_o, cmd_reg_o, cmd_val_o}, 0);
    chk({tag, "_flags"}, {29'd0, busy_o, done_o, error_o}, 0);
    chk({tag, "_err_index"}, 32'(err_index_o), 0);
    chk({tag, "_write_count"}, 32'(write_count_o), 0);
  endtask

  task automatic run_and_check(input string tag, input bit mid_starts);
    int st;
    int to;
    hs_log.delete(); resp_cyc.delete(); rise_cyc.delete();
    build_model();
    @(negedge clk_i);
    start_i = 1'b1; st = cyc;
    @(negedge clk_i);
    start_i = 1'b0;
    chk({tag, "_started"}, {29'd0, busy_o, done_o, error_o}, 32'b100);
    if (mid_starts) begin
      repeat (4) @(negedge clk_i);
      start_i = 1'b1; @(negedge clk_i); start_i = 1'b0;
      repeat (6) @(negedge clk_i);
      start_i = 1'b1; @(negedge clk_i); start_i = 1'b0;
    end
    to = 0;
    while (busy_o && to < 20000) begin
      @(negedge clk_i);
      to++;
    end
    chk({tag, "_finished_in_time"}, 32'(to < 20000), 1);
    chk({tag, "_done_error"}, {30'd0, done_o, error_o}, {30'd0, !exp_err, exp_err});
    repeat (4) @(negedge clk_i);
    chk({tag, "_idle_flags"}, {29'd0, busy_o, done_o, error_o}, {29'd0, 1'b0, !exp_err, exp_err});
    chk({tag, "_write_count"}, 32'(write_count_o), 32'(exp_wc));
    if (exp_err) chk({tag, "_err_index"}, 32'(err_index_o), 32'(exp_err_idx));
    chk({tag, "_num_handshakes"}, 32'(hs_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < hs_log.size() && i < exp_log.size(); i++)
      chk({tag, "_handshake"}, 32'(hs_log[i]), 32'(exp_log[i]));
    if (rise_cyc.size() > 0 && exp_log.size() > 0)
      chk({tag, "_first_latency"}, 32'(rise_cyc[0] - st), 32'(exp_first));
    for (int i = 1; i < exp_log.size() && i < rise_cyc.size() && i <= resp_cyc.size(); i++)
      chk({tag, "_gap"}, 32'(rise_cyc[i] - resp_cyc[i-1]), 32'(exp_gap[i-1]));
  endtask

  task automatic fill_rom_random();
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
  endtask

  initial begin
    int len;
    int to;
    rst_i = 1'b1; start_i = 1'b0;
    fill_rom_random();
    repeat (3) @(negedge clk_i);
    chk_reset_outputs("reset");
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Basic walk with a zero-length delay between two writes.
    rom[0] = 16'h1280; rom[1] = 16'hFF00; rom[2] = 16'h1100; rom[3] = 16'hFFFF;
    plan.delete(); ack_lat = 2;
    run_and_check("basic", 1'b0);

    rom[1] = 16'hFF03;
    run_and_check("delay3", 1'b0);

    rom[0] = 16'h40D0; rom[1] = 16'hFFFF;
    plan = '{2};
    run_and_check("retry2", 1'b0);

    for (int i = 0; i < 6; i++) rom[i] = {8'(8'h20 + i), 8'($urandom)};
    rom[6] = 16'hFFFF;
    plan = '{0, 0, 0, 0, 0, 4};
    run_and_check("nack_abort", 1'b0);
    plan.delete();
    run_and_check("rerun_after_error", 1'b0);

    rom[0] = 16'h40D0; rom[1] = 16'h1234; rom[2] = 16'hFFFF;
    stall_req = 7;
    run_and_check("stall_midstart", 1'b1);

    for (int it = 0; it < 4; it++) begin
      fill_rom_random();
      len = $urandom_range(4, 16);
      plan.delete();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          rom[i] = {8'hFF, 8'($urandom_range(0, 4))};
        end else begin
          rom[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
          plan.push_back(($urandom_range(0, 9) > 7) ? 4 : $urandom_range(0, 2));
        end
      end
      rom[len] = 16'hFFFF;
      ack_lat = $urandom_range(1, 3);
      run_and_check("random", 1'b0);
    end

    // Reset while waiting out a delay entry.
    rom[0] = 16'h1280; rom[1] = 16'hFF05; rom[2] = 16'h1100; rom[3] = 16'hFFFF;
    plan.delete(); ack_lat = 2;
    build_model();
    resp_cyc.delete();
    @(negedge clk_i); start_i = 1'b1; @(negedge clk_i); start_i = 1'b0;
    to = 0;
    while (resp_cyc.size() < 1 && to < 200) begin @(negedge clk_i); to++; end
    chk("rst_wait_reached", 32'(to < 200), 1);
    repeat (10) @(negedge clk_i);
    chk("rst_wait_busy", {30'd0, busy_o, cmd_valid_o}, 32'b10);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk_reset_outputs("rst_wait");
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);

    // Reset while a command is held off by cmd_ready.
    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    stall_req = 30;
    @(negedge clk_i); start_i = 1'b1; @(negedge clk_i); start_i = 1'b0;
    to = 0;
    while (!cmd_valid_o && to < 50) begin @(negedge clk_i); to++; end
    repeat (3) @(negedge clk_i);
    chk("rst_send_valid", 32'(cmd_valid_o), 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk_reset_outputs("rst_send");
    @(negedge clk_i);
    rst_i = 1'b0;
    stall_req = 0;
    repeat (4) @(negedge clk_i);

    // Full ROM with no end marker finishes after index 255.
    for (int i = 0; i < 256; i++) rom[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
    plan.delete(); ack_lat = 1;
    run_and_check("full_rom", 1'b0);
    chk("full_rom_last_addr", 32'(rom_addr_o), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
